// File: rtl/sub_pkg.sv
// Shared types and sizing helpers for the multicycle subtractor.
// Holds the FSM state enum and slice/index width functions.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int nslice(input int w, input int s);
    return w / s;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/full_subtractor_slice.sv
// Combinational SLICE-bit ripple-borrow subtractor: d = a - b - bin.
// Time-multiplexed by the top across all slices of the operands.
module full_subtractor_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             bin,
  output logic [SLICE-1:0] d,
  output logic             bout
);

  logic c;

  always_comb begin
    d = '0;
    c = bin;
    for (int i = 0; i < SLICE; i++) begin
      d[i] = a[i] ^ b[i] ^ c;
      c = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & c);
    end
    bout = c;
  end

endmodule

// File: rtl/multicycle_subtractor.sv
// Multicycle A - B - Bin, one SLICE-bit slice per clock, valid/ready I/O.
// Define SUB_SATURATE_EN to saturate Diff on signed overflow.
module multicycle_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Ovf
);

  localparam int NSLICE = nslice(WIDTH, SLICE);
  localparam int IW = idx_w(NSLICE);
  localparam int MSB = WIDTH - 1;
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

  if (WIDTH % SLICE != 0) begin : g_chk
    $error("WIDTH must be a multiple of SLICE");
  end

`ifdef SUB_SATURATE_EN
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  state_t          state;
  logic [IW-1:0]   idx;
  logic            borrow;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic [SLICE-1:0] a_s;
  logic [SLICE-1:0] b_s;
  logic [SLICE-1:0] d_s;
  logic             bo_s;
  logic [WIDTH-1:0] d_n;
  logic             ovf_n;
  int               base;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  full_subtractor_slice #(.SLICE(SLICE)) u_slice (
    .a   (a_s),
    .b   (b_s),
    .bin (borrow),
    .d   (d_s),
    .bout(bo_s)
  );

  // Ovf looks at the MSB as it will be after this slice is written.
  always_comb begin
    base  = int'(idx) * SLICE;
    a_s   = a_q[base +: SLICE];
    b_s   = b_q[base +: SLICE];
    d_n   = Diff;
    d_n[base +: SLICE] = d_s;
    ovf_n = (a_q[MSB] != b_q[MSB]) && (d_n[MSB] != a_q[MSB]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      borrow <= 1'b0;
      Diff   <= '0;
      Bout   <= 1'b0;
      Ovf    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q    <= A;
            b_q    <= B;
            borrow <= Bin;
            idx    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          Diff   <= d_n;
          borrow <= bo_s;
          if (idx == LAST) begin
            Bout  <= bo_s;
            Ovf   <= ovf_n;
            state <= DONE;
`ifdef SUB_SATURATE_EN
            if (ovf_n)
              Diff <= a_q[MSB] ? SAT_NEG : SAT_POS;
`endif
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_subtractor.sv
// Scoreboard bench for multicycle_subtractor with a reference model.
// Driver pushes expected results; monitor pops on each output.
module tb_multicycle_subtractor;

  localparam int W = 16;
  localparam int S = 4;
  localparam int NS = W / S;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    int           acc;
  } exp_t;

  logic         clk = 0;
  logic         rst = 1;
  logic         in_valid = 0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Bin = 0;
  logic         out_valid;
  logic         out_ready = 1;
  logic [W-1:0] Diff;
  logic         Bout;
  logic         Ovf;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   bpmode = 0;
  int   vcount = 0;
  bit   have = 0;
  exp_t cur;
  exp_t q[$];

  multicycle_subtractor #(.WIDTH(W), .SLICE(S)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .Bin      (Bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Diff     (Diff),
    .Bout     (Bout),
    .Ovf      (Ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at cycle %0d", nm, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic bi);
    exp_t e;
    int   r;
    r      = int'($signed(a)) - int'($signed(b)) - int'(bi);
    e.ovf  = (r > 32767) || (r < -32768);
    e.bout = int'(a) < int'(b) + int'(bi);
    e.diff = W'(int'(a) - int'(b) - int'(bi));
`ifdef SUB_SATURATE_EN
    if (e.ovf)
      e.diff = (r > 0) ? 16'h7FFF : 16'h8000;
`endif
    e.acc = 0;
    return e;
  endfunction

  // Offer operands and hold them until the DUT takes them.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic bi, input bit push);
    exp_t e;
    int   n;
    @(posedge clk); #1;
    in_valid = 1; A = a; B = b; Bin = bi;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout a=%0h b=%0h", a, b);
    end else if (push) begin
      e = model(a, b, bi);
      e.acc = cyc + 1;
      q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 0;
    A = W'($urandom);
    B = W'($urandom);
    Bin = 1'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid || !in_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d", q.size());
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (bpmode)
      0: out_ready = 1;
      1: out_ready = 1'($urandom_range(0, 2) != 0);
      default: out_ready = (vcount >= 5);
    endcase
  end

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (!have) begin
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output Diff=%0h", Diff);
        end else begin
          cur = q.pop_front();
          have = 1;
          chk("latency", cyc - cur.acc, NS);
          chk("diff", Diff, cur.diff);
          chk("bout", Bout, cur.bout);
          chk("ovf", Ovf, cur.ovf);
        end
      end else begin
        chk("diff_hold", Diff, cur.diff);
        chk("bout_hold", Bout, cur.bout);
        chk("ovf_hold", Ovf, cur.ovf);
      end
      chk("in_ready_done", in_ready, 0);
      vcount++;
      if (out_ready) begin
        have = 0;
        vcount = 0;
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", Diff, 0);
    chk("rst_bout", Bout, 0);
    chk("rst_ovf", Ovf, 0);

    send(16'h1234, 16'h0234, 0, 1);
    send(16'h0000, 16'h0001, 0, 1);
    send(16'h0005, 16'h0005, 1, 1);
    send(16'h8000, 16'h0001, 0, 1);
    send(16'h7FFF, 16'hFFFF, 0, 1);
    send(16'hFFFF, 16'h0000, 1, 1);
    drain();

    // Backpressure: second op waits with in_valid high through DONE.
    bpmode = 2;
    send(16'hA5A5, 16'h1111, 0, 1);
    send(16'h4000, 16'hC000, 1, 1);
    drain();
    bpmode = 0;

    // Reset after two slices of RUN discards the operation.
    send(16'hBEEF, 16'h1234, 1, 0);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_diff", Diff, 0);
    chk("mid_rst_bout", Bout, 0);
    chk("mid_rst_ovf", Ovf, 0);
    send(16'h00FF, 16'h000F, 0, 1);
    drain();

    bpmode = 1;
    for (int i = 0; i < 60; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = W'($urandom);
      b = W'($urandom);
      if (i % 10 == 0) a = 16'h8000;
      if (i % 10 == 5) b = 16'h7FFF;
      send(a, b, 1'($urandom), 1);
    end
    drain();

    chk("leftover", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_subtractor.md
Name: multicycle_subtractor

Overview:
- Computes A - B - Bin over WIDTH bits, one SLICE-bit ripple-borrow slice per clock.
- Complement of the ripple-carry adder path; serves filter datapaths that need error or difference terms and can trade latency for area.
- Valid/ready handshake on both input and output; one operation in flight at a time.

Parameters:
WIDTH, 16, operand and result width in bits; must be an integer multiple of SLICE, otherwise elaboration fails.
SLICE, 4, bits processed per cycle; the slice count is NSLICE = WIDTH/SLICE.

Ports:
clk  input  1  sole clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operands valid.
in_ready  output  1  block can accept operands.
A  input  WIDTH  minuend.
B  input  WIDTH  subtrahend.
Bin  input  1  borrow-in.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts the result.
Diff  output  WIDTH  difference.
Bout  output  1  borrow-out; 1 iff A < B + Bin (unsigned).
Ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset:
  - Applies only on a clk edge while rst=1.
  - Puts the FSM in IDLE. Clears the slice index, borrow register, Diff, Bout, Ovf and out_valid to 0.
  - rst overrides every other input in every state, including mid-RUN and DONE. The in-flight operation is discarded with no output.
- FSM states: IDLE, RUN, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
- IDLE:
  - If in_valid=1, the edge latches A, B, Bin into the operand registers, sets idx=0 and borrow=Bin, and moves to RUN.
  - Otherwise the block stays in IDLE.
- RUN:
  - Each edge computes bits [idx*SLICE +: SLICE] = A_slice - B_slice - borrow.
  - The slice result is written into the Diff register and the slice borrow-out goes into the borrow register; idx then increments.
  - On the edge that computes slice NSLICE-1:
    - Bout is set to the final borrow.
    - Ovf is set to (A[MSB] != B[MSB]) && (Diff[MSB] != A[MSB]), using the latched operands.
    - The state moves to DONE.
  - in_valid is ignored throughout RUN.
- DONE:
  - Diff, Bout and Ovf hold stable while out_ready=0 (any number of cycles).
  - With out_ready=1, the edge moves to IDLE. out_valid drops and in_ready rises in the following cycle.
  - No back-to-back acceptance: in_valid in the DONE cycle is not accepted.
- Latency: out_valid is high exactly NSLICE cycles after the acceptance edge (4 at defaults).
- Throughput: one result per NSLICE+2 cycles with no backpressure.
- Intermediate behaviour:
  - Diff bits not yet computed retain their previous-operation values during RUN. They are not observable because out_valid=0.
  - Diff, Bout and Ovf are registered outputs. They remain valid in IDLE after the handshake until the next DONE overwrites them.
- Arithmetic:
  - Modulo 2^WIDTH.
  - Bin=1 subtracts one more.
  - The borrow chain crosses slice boundaries only through the borrow register; there is no combinational path across slices.

Optional Feature:
- Macro SUB_SATURATE_EN.
- Defined: when Ovf=1, Diff is replaced at the final edge by the signed saturation value.
  - A[MSB]=0 gives 0111...1.
  - A[MSB]=1 gives 1000...0.
  - Ovf and Bout still report the raw condition.
- Undefined: Diff wraps; no saturation logic is present.

Decomposition:
- Package sub_pkg holds:
  - the FSM state enum (IDLE, RUN, DONE);
  - the helper function for NSLICE and the idx width, clog2(NSLICE) with a minimum of 1.
- One sub-module, full_subtractor_slice: purely combinational SLICE-bit ripple-borrow subtractor.
  - Inputs: a, b, bin.
  - Outputs: d, bout.
  - Built from per-bit diff = a^b^bin and borrow = (~a&b) | (~(a^b)&bin).
  - Instantiated once and time-multiplexed over slices.

Test Plan:
1. WIDTH=16, SLICE=4; A=0x1234, B=0x0234, Bin=0 -> Diff=0x1000, Bout=0, Ovf=0; out_valid rises exactly 4 cycles after the acceptance edge.
2. A=0x0000, B=0x0001, Bin=0 -> Diff=0xFFFF, Bout=1, Ovf=0 (borrow ripples through all 4 slices). Then A=0x0005, B=0x0005, Bin=1 -> Diff=0xFFFF, Bout=1.
3. A=0x8000, B=0x0001 -> Ovf=1, Bout=0; Diff=0x7FFF without the macro, 0x8000 with SUB_SATURATE_EN.
4. A=0x7FFF, B=0xFFFF -> Ovf=1, Bout=1; Diff=0x8000 without the macro, 0x7FFF with SUB_SATURATE_EN.
5. Hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands -> Diff, Bout, Ovf stable and in_ready=0 throughout. The new operands are not captured until the cycle after out_ready=1 completes the handshake, then they produce the correct result.
6. Assert rst for one cycle after 2 slices of RUN -> next cycle state=IDLE, in_ready=1, out_valid=0, Diff=0, Bout=0, Ovf=0. A following operation A=0x00FF, B=0x000F yields Diff=0x00F0, Bout=0.
